mul_shift_add: RTL and testbench

Sequential unsigned shift-and-add multiplier. It sits directly downstream of the dual-read-port register RAM: its two operands come from RAM `oDataOut0`/`oDataOut1`, and its product goes back into the RAM multiplier write port (`iDataInMul`/`iMulEnable`, fixed address 8). It takes one operand bit per cycle, so latency is fixed, and it signals completion with a single-cycle write strobe.

---
 rtl/mul_shift_add_pkg.sv | 11 +
 rtl/mul_shift_add_if.sv | 35 +++
 rtl/mul_shift_add.sv | 79 +++++++
 tb/tb_mul_shift_add.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_shift_add_pkg.sv
// Shared definitions for the shift-and-add multiplier slice:
// controller state codes and the RAM slot that receives the product.
package mul_shift_add_pkg;

  localparam logic [1:0] MUL_IDLE = 2'd0;
  localparam logic [1:0] MUL_RUN  = 2'd1;
  localparam logic [1:0] MUL_DONE = 2'd2;

  localparam logic [7:0] MUL_RESULT_ADDR = 8'd8;

endpackage

// File: rtl/mul_shift_add_if.sv
// Operand/result bundle between the register RAM side and the multiplier.
// master: controller/RAM side; slave: the multiplier.
interface mul_shift_add_if #(
  parameter int DATA_WIDTH = 16
);

  logic                  iStart;
  logic [DATA_WIDTH-1:0] iDataA;
  logic [DATA_WIDTH-1:0] iDataB;
  logic                  oBusy;
  logic                  oMulEnable;
  logic [DATA_WIDTH-1:0] oResult;
  logic                  oOverflow;

  modport master (
    output iStart,
    output iDataA,
    output iDataB,
    input  oBusy,
    input  oMulEnable,
    input  oResult,
    input  oOverflow
  );

  modport slave (
    input  iStart,
    input  iDataA,
    input  iDataB,
    output oBusy,
    output oMulEnable,
    output oResult,
    output oOverflow
  );

endinterface

// File: rtl/mul_shift_add.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per cycle.
// Ports: Clock, Reset (sync, active-high), bus (slave): start/operands in, busy/strobe/result/overflow out.
module mul_shift_add
  import mul_shift_add_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 5
) (
  input logic           Clock,
  input logic           Reset,
  mul_shift_add_if.slave bus
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(DATA_WIDTH - 1);

  logic [1:0]            rState;
  logic [PW-1:0]         rMcand;
  logic [PW-1:0]         rAcc;
  logic [DATA_WIDTH-1:0] rMplier;
  logic [CNT_WIDTH-1:0]  rCnt;
  logic [PW-1:0]         wAccNext;

  // Includes the add of the current bit, so the last RUN edge
  // can publish the finished product directly.
  always_comb begin
    wAccNext = rAcc;
    if (rMplier[0])
      wAccNext = rAcc + rMcand;
  end

  assign bus.oBusy = (rState != MUL_IDLE);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rState         <= MUL_IDLE;
      rMcand         <= '0;
      rAcc           <= '0;
      rMplier        <= '0;
      rCnt           <= '0;
      bus.oMulEnable <= 1'b0;
      bus.oResult    <= '0;
      bus.oOverflow  <= 1'b0;
    end else begin
      bus.oMulEnable <= 1'b0;
      case (rState)
        MUL_IDLE: begin
          if (bus.iStart) begin
            rMcand  <= {{DATA_WIDTH{1'b0}}, bus.iDataA};
            rMplier <= bus.iDataB;
            rAcc    <= '0;
            rCnt    <= '0;
            rState  <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          rAcc    <= wAccNext;
          rMcand  <= rMcand << 1;
          rMplier <= rMplier >> 1;
          rCnt    <= rCnt + CNT_WIDTH'(1);
          if (rCnt == LAST) begin
            bus.oResult    <= wAccNext[DATA_WIDTH-1:0];
            bus.oOverflow  <= |wAccNext[PW-1:DATA_WIDTH];
            bus.oMulEnable <= 1'b1;
            rState         <= MUL_DONE;
          end
        end
        MUL_DONE: begin
          rState <= MUL_IDLE;
        end
        default: begin
          rState <= MUL_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_shift_add.sv
// Randomized + directed bench for mul_shift_add with a cycle-level
// behavioural model; a second 8-bit instance covers the narrow case.
module tb_mul_shift_add;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  always #5 Clock = ~Clock;

  mul_shift_add_if #(.DATA_WIDTH(16)) bus ();
  mul_shift_add_if #(.DATA_WIDTH(8))  bus8 ();

  mul_shift_add #(.DATA_WIDTH(16), .CNT_WIDTH(5)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  mul_shift_add #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut8 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus8)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: an accepted start at edge n0 produces the
  // strobe and new result after edge n0+16; busy spans edges n0..n0+16;
  // the next start can be taken at edge n0+18.
  int          edge_n  = 0;
  int          next_ok = 0;
  int          n0      = 0;
  bit          act     = 0;
  logic [15:0] eA, eB;
  logic [15:0] exp_res = '0;
  logic        exp_ovf = 1'b0;
  logic [31:0] full;
  logic [15:0] ram8    = '0;
  int          strobes[$];

  always @(posedge Clock) begin
    edge_n++;
    if (Reset) begin
      act     = 0;
      exp_res = '0;
      exp_ovf = 1'b0;
      next_ok = edge_n + 1;
    end else begin
      if (act && edge_n == n0 + 16) begin
        full    = 32'(eA) * 32'(eB);
        exp_res = full[15:0];
        exp_ovf = |full[31:16];
      end
      if (bus.iStart && edge_n >= next_ok) begin
        act     = 1;
        n0      = edge_n;
        eA      = bus.iDataA;
        eB      = bus.iDataB;
        next_ok = edge_n + 18;
      end
    end
  end

  // Stand-in for the RAM slot at MUL_RESULT_ADDR.
  always @(posedge Clock)
    if (bus.oMulEnable) ram8 <= bus.oResult;

  always @(negedge Clock) begin
    if (edge_n > 0) begin
      chk("busy", 32'(bus.oBusy),
          32'(act && edge_n <= n0 + 16));
      chk("strobe", 32'(bus.oMulEnable),
          32'(act && edge_n == n0 + 16));
      chk("result", 32'(bus.oResult), 32'(exp_res));
      chk("overflow", 32'(bus.oOverflow), 32'(exp_ovf));
      if (bus.oMulEnable) strobes.push_back(edge_n);
    end
  end

  task automatic do_op(input logic [15:0] a,
                       input logic [15:0] b,
                       output logic [15:0] r,
                       output logic o,
                       output int lat);
    @(negedge Clock);
    bus.iStart = 1'b1;
    bus.iDataA = a;
    bus.iDataB = b;
    lat = -1;
    r = 'x;
    o = 1'bx;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (i == 0) bus.iStart = 1'b0;
      if (bus.oMulEnable) begin
        lat = i;
        r = bus.oResult;
        o = bus.oOverflow;
        break;
      end
    end
    if (lat < 0) chk("op_timeout", 32'(lat), 32'd16);
  endtask

  logic [15:0] r;
  logic        o;
  int          lat;
  int          cnt;

  initial begin
    bus.iStart  = 1'b0;
    bus.iDataA  = '0;
    bus.iDataB  = '0;
    bus8.iStart = 1'b0;
    bus8.iDataA = '0;
    bus8.iDataB = '0;
    repeat (2) @(negedge Clock);
    chk("rst_busy", 32'(bus.oBusy), 32'd0);
    chk("rst_strobe", 32'(bus.oMulEnable), 32'd0);
    chk("rst_result", 32'(bus.oResult), 32'd0);
    chk("rst_ovf", 32'(bus.oOverflow), 32'd0);
    Reset = 1'b0;

    do_op(16'd3, 16'd5, r, o, lat);
    chk("p3x5_lat", 32'(lat), 32'd16);
    chk("p3x5_res", 32'(r), 32'd15);
    chk("p3x5_ovf", 32'(o), 32'd0);
    chk("p3x5_model", 32'(exp_res), 32'd15);
    @(negedge Clock);
    chk("p3x5_ram8", 32'(ram8), 32'd15);
    chk("p3x5_strobe_off", 32'(bus.oMulEnable), 32'd0);

    do_op(16'hFFFF, 16'hFFFF, r, o, lat);
    chk("pffff_res", 32'(r), 32'h0001);
    chk("pffff_ovf", 32'(o), 32'd1);
    chk("pffff_model", 32'({exp_ovf, exp_res}), 32'h10001);

    do_op(16'h0100, 16'h00FF, r, o, lat);
    chk("p100_res", 32'(r), 32'hFF00);
    chk("p100_ovf", 32'(o), 32'd0);

    do_op(16'h0000, 16'h1234, r, o, lat);
    chk("pzero_res", 32'(r), 32'd0);
    chk("pzero_lat", 32'(lat), 32'd16);

    // Random starts, some landing while busy and therefore ignored.
    for (int i = 0; i < 400; i++) begin
      @(negedge Clock);
      bus.iStart = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0: bus.iDataA = 16'hFFFF;
        1: bus.iDataA = 16'h0000;
        default: bus.iDataA = 16'($urandom);
      endcase
      bus.iDataB = 16'($urandom);
    end
    bus.iStart = 1'b0;
    repeat (20) @(negedge Clock);

    // Start held high, operands churning every cycle.
    strobes.delete();
    bus.iStart = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge Clock);
      bus.iDataA = 16'($urandom);
      bus.iDataB = 16'($urandom);
    end
    bus.iStart = 1'b0;
    repeat (20) @(negedge Clock);
    chk("held_count_ge3", 32'(strobes.size() >= 3), 32'd1);
    for (int i = 1; i < strobes.size(); i++)
      chk("held_spacing", 32'(strobes[i] - strobes[i-1]), 32'd18);

    // Reset landing on E8 of a run must abort it silently.
    @(negedge Clock);
    bus.iStart = 1'b1;
    bus.iDataA = 16'd7;
    bus.iDataB = 16'd9;
    @(negedge Clock);
    bus.iStart = 1'b0;
    repeat (6) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("abort_busy", 32'(bus.oBusy), 32'd0);
    chk("abort_strobe", 32'(bus.oMulEnable), 32'd0);
    chk("abort_result", 32'(bus.oResult), 32'd0);
    chk("abort_ovf", 32'(bus.oOverflow), 32'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (bus.oMulEnable) cnt++;
    end
    chk("abort_no_strobe", 32'(cnt), 32'd0);
    do_op(16'd7, 16'd9, r, o, lat);
    chk("p7x9_res", 32'(r), 32'd63);
    chk("p7x9_lat", 32'(lat), 32'd16);

    // Narrow instance.
    @(negedge Clock);
    bus8.iStart = 1'b1;
    bus8.iDataA = 8'h10;
    bus8.iDataB = 8'h10;
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clock);
      if (i == 0) bus8.iStart = 1'b0;
      if (bus8.oMulEnable) begin
        lat = i;
        break;
      end
    end
    chk("w8_lat", 32'(lat), 32'd8);
    chk("w8_res", 32'(bus8.oResult), 32'h00);
    chk("w8_ovf", 32'(bus8.oOverflow), 32'd1);
    @(negedge Clock);
    chk("w8_strobe_off", 32'(bus8.oMulEnable), 32'd0);

    repeat (3) @(negedge Clock);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
